core3_timer_arbiter: RTL and testbench

CORE3_TIMER_ARBITER -- requirements
Module: core3_timer_arbiter

---
 rtl/core3_timer_arbiter.sv | 160 ++++++++++++++++
 tb/tb_core3_timer_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/core3_timer_arbiter.sv
// core3_timer_arbiter: round-robin arbiter that lets NUM_MASTERS Avalon-MM
// masters share a single timer slave. Each transaction is one IDLE -> ACCESS
// -> DONE pass, so the minimum latency is three cycles.
//
// Optional build macro: TIMER_IRQ_ROUTE_EN
//   defined   - the timer interrupt goes only to the master that last armed it
//               (a write to address 1 with writedata[0]=1)
//   undefined - the timer interrupt is broadcast to every master
module core3_timer_arbiter #(
   parameter int unsigned NUM_MASTERS = 3
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic [NUM_MASTERS-1:0]      m_chipselect,
   input  logic [NUM_MASTERS-1:0]      m_write_n,
   input  logic [3*NUM_MASTERS-1:0]    m_address,
   input  logic [16*NUM_MASTERS-1:0]   m_writedata,
   output logic [15:0]                 m_readdata,
   output logic [NUM_MASTERS-1:0]      m_waitrequest,
   output logic                        s_chipselect,
   output logic                        s_write_n,
   output logic [2:0]                  s_address,
   output logic [15:0]                 s_writedata,
   input  logic [15:0]                 s_readdata,
   input  logic                        irq_in,
   output logic [NUM_MASTERS-1:0]      irq_out
);

   localparam int unsigned IDX_W  = 2;
   localparam int unsigned ADDR_W = 3;
   localparam int unsigned DATA_W = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t              state;
   logic [IDX_W-1:0]    grant;
   logic [IDX_W-1:0]    last_grant;

   logic [IDX_W-1:0]    pick;
   logic                any_req;
   logic                sel_write_n;
   logic [ADDR_W-1:0]   sel_address;
   logic [DATA_W-1:0]   sel_writedata;

   // Round-robin search starting just after the last served master; the
   // loop runs from the farthest offset down so the nearest requester wins.
   always_comb begin
      logic [IDX_W-1:0] idx;
      idx     = '0;
      pick    = '0;
      any_req = 1'b0;
      for (int k = int'(NUM_MASTERS) - 1; k >= 0; k--) begin
         idx = IDX_W'((int'(last_grant) + 1 + k) % int'(NUM_MASTERS));
         if (m_chipselect[idx]) begin
            pick    = idx;
            any_req = 1'b1;
         end
      end
   end

   // Mux the picked master's command fields toward the slave registers.
   always_comb begin
      sel_write_n   = 1'b1;
      sel_address   = '0;
      sel_writedata = '0;
      for (int i = 0; i < int'(NUM_MASTERS); i++) begin
         if (pick == IDX_W'(i)) begin
            sel_write_n   = m_write_n[i];
            sel_address   = m_address[ADDR_W*i +: ADDR_W];
            sel_writedata = m_writedata[DATA_W*i +: DATA_W];
         end
      end
   end

   // Transaction FSM with the registered slave-side command outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         last_grant   <= IDX_W'(NUM_MASTERS - 1);
         grant        <= '0;
         s_chipselect <= 1'b0;
         s_write_n    <= 1'b1;
         s_address    <= '0;
         s_writedata  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (any_req) begin
                  state        <= ACCESS;
                  grant        <= pick;
                  s_chipselect <= 1'b1;
                  s_write_n    <= sel_write_n;
                  s_address    <= sel_address;
                  s_writedata  <= sel_writedata;
               end
            end
            ACCESS: begin
               // The slave captures the command this cycle; the master
               // completes in DONE whether or not it still requests.
               state        <= DONE;
               s_chipselect <= 1'b0;
               s_write_n    <= 1'b1;
            end
            DONE: begin
               state      <= IDLE;
               last_grant <= grant;
            end
            default: begin
               state        <= IDLE;
               s_chipselect <= 1'b0;
               s_write_n    <= 1'b1;
            end
         endcase
      end
   end

   // Read data is the slave's registered reply, visible only in DONE.
   always_comb begin
      m_readdata = (state == DONE) ? s_readdata : 16'h0000;
   end

   // Stall every requester except the granted one during its DONE cycle.
   always_comb begin
      m_waitrequest = '0;
      for (int i = 0; i < int'(NUM_MASTERS); i++) begin
         m_waitrequest[i] = m_chipselect[i] &
                            ~((state == DONE) && (grant == IDX_W'(i)));
      end
   end

`ifdef TIMER_IRQ_ROUTE_EN
   logic [IDX_W-1:0] irq_owner;

   // Remember which master last enabled the timer interrupt.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         irq_owner <= '0;
      end else if ((state == ACCESS) && !s_write_n &&
                   (s_address == 3'd1) && s_writedata[0]) begin
         irq_owner <= grant;
      end
   end

   // Route the interrupt only to the owning master.
   always_comb begin
      irq_out = '0;
      for (int i = 0; i < int'(NUM_MASTERS); i++) begin
         irq_out[i] = irq_in & (irq_owner == IDX_W'(i));
      end
   end
`else
   // Broadcast the interrupt to every master.
   assign irq_out = {NUM_MASTERS{irq_in}};
`endif

endmodule

// File: tb/tb_core3_timer_arbiter.sv
// Directed bench for core3_timer_arbiter: reset values, single read latency,
// three-way contention, round-robin fairness, mid-transaction reset and
// interrupt routing (both builds of TIMER_IRQ_ROUTE_EN).
module tb_core3_timer_arbiter;

   localparam int unsigned NM = 3;

   logic              clk = 1'b0;
   logic              reset_n;
   logic [NM-1:0]     m_chipselect;
   logic [NM-1:0]     m_write_n;
   logic [3*NM-1:0]   m_address;
   logic [16*NM-1:0]  m_writedata;
   logic [15:0]       m_readdata;
   logic [NM-1:0]     m_waitrequest;
   logic              s_chipselect;
   logic              s_write_n;
   logic [2:0]        s_address;
   logic [15:0]       s_writedata;
   logic [15:0]       s_readdata;
   logic              irq_in;
   logic [NM-1:0]     irq_out;

   int checks = 0;
   int errors = 0;

   // Per-window observation logs
   logic [15:0]   acc_data [8];
   logic [2:0]    acc_addr [8];
   logic          acc_wn   [8];
   int            acc_cyc  [8];
   int            acc_cnt;
   int            done_at  [NM];
   logic [15:0]   rd_log   [16];
   logic [NM-1:0] wr_log   [16];
   logic [15:0]   sc_log;

   logic [NM-1:0] irq_pre_exp;
   logic [NM-1:0] irq_post_exp;

   core3_timer_arbiter #(.NUM_MASTERS(NM)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .m_chipselect  (m_chipselect),
      .m_write_n     (m_write_n),
      .m_address     (m_address),
      .m_writedata   (m_writedata),
      .m_readdata    (m_readdata),
      .m_waitrequest (m_waitrequest),
      .s_chipselect  (s_chipselect),
      .s_write_n     (s_write_n),
      .s_address     (s_address),
      .s_writedata   (s_writedata),
      .s_readdata    (s_readdata),
      .irq_in        (irq_in),
      .irq_out       (irq_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic set_master(input int i, input logic wn, input logic [2:0] a, input logic [15:0] d);
      m_write_n[i]          = wn;
      m_address[3*i +: 3]   = a;
      m_writedata[16*i +: 16] = d;
   endtask

   task automatic do_reset();
      reset_n      = 1'b0;
      m_chipselect = '0;
      @(posedge clk);
      @(negedge clk);
      @(posedge clk);
      #1 reset_n = 1'b1;
   endtask

   // Run ncyc cycles (cycle 0 = first negedge), logging slave accesses and
   // completions. A completing master drops its request unless held; the
   // late mask is raised right after cycle late_cyc.
   task automatic run_cycles(input int ncyc, input logic [NM-1:0] hold,
                             input logic [NM-1:0] late, input int late_cyc);
      logic [NM-1:0] done_now;
      acc_cnt = 0;
      sc_log  = '0;
      for (int i = 0; i < int'(NM); i++) done_at[i] = -1;
      for (int c = 0; c < ncyc; c++) begin
         @(negedge clk);
         sc_log[c] = s_chipselect;
         rd_log[c] = m_readdata;
         wr_log[c] = m_waitrequest;
         if (s_chipselect && acc_cnt < 8) begin
            acc_data[acc_cnt] = s_writedata;
            acc_addr[acc_cnt] = s_address;
            acc_wn[acc_cnt]   = s_write_n;
            acc_cyc[acc_cnt]  = c;
            acc_cnt++;
         end
         done_now = m_chipselect & ~m_waitrequest;
         for (int i = 0; i < int'(NM); i++) if (done_now[i]) done_at[i] = c;
         @(posedge clk);
         #1;
         m_chipselect = m_chipselect & ~(done_now & ~hold);
         if (c == late_cyc) m_chipselect = m_chipselect | late;
      end
   endtask

   initial begin
      reset_n      = 1'b0;
      m_chipselect = '0;
      m_write_n    = '1;
      m_address    = '0;
      m_writedata  = '0;
      s_readdata   = 16'h0000;
      irq_in       = 1'b0;

      // Reset values
      repeat (2) @(negedge clk);
      check("rst_s_cs",   32'(s_chipselect),  32'h0);
      check("rst_s_wn",   32'(s_write_n),     32'h1);
      check("rst_s_addr", 32'(s_address),     32'h0);
      check("rst_s_data", 32'(s_writedata),   32'h0);
      check("rst_rdata",  32'(m_readdata),    32'h0);
      check("rst_wait",   32'(m_waitrequest), 32'h0);
      check("rst_irq",    32'(irq_out),       32'h0);
      m_chipselect = 3'b101;
      #1 check("rst_wait_req", 32'(m_waitrequest), 32'h5);
      m_chipselect = '0;
      @(posedge clk);
      #1 reset_n = 1'b1;

      // Single read: master 1, address 0
      set_master(1, 1'b1, 3'd0, 16'h0000);
      s_readdata   = 16'h0002;
      m_chipselect = 3'b010;
      run_cycles(4, '0, '0, -1);
      check("rd_scs_bits", 32'(sc_log[3:0]), 32'h2);
      check("rd_rdata_c1", 32'(rd_log[1]), 32'h0);
      check("rd_rdata_c2", 32'(rd_log[2]), 32'h0002);
      check("rd_wait_bits", 32'({wr_log[3][1], wr_log[2][1], wr_log[1][1], wr_log[0][1]}), 32'h3);
      check("rd_done_cyc", 32'(done_at[1]), 32'd2);
      check("rd_acc_wn",   32'(acc_wn[0]), 32'h1);
      check("rd_acc_addr", 32'(acc_addr[0]), 32'h0);
      s_readdata = 16'h0000;

      // Contention from reset: all three write address 2
      do_reset();
      for (int i = 0; i < int'(NM); i++) set_master(i, 1'b0, 3'd2, 16'hA000 + 16'(i));
      m_chipselect = 3'b111;
      run_cycles(10, '0, '0, -1);
      check("ct_count", 32'(acc_cnt), 32'd3);
      for (int n = 0; n < 3; n++) begin
         check($sformatf("ct_cyc%0d", n),  32'(acc_cyc[n]),  32'(1 + 3*n));
         check($sformatf("ct_data%0d", n), 32'(acc_data[n]), 32'(16'hA000 + 16'(n)));
         check($sformatf("ct_wn%0d", n),   32'(acc_wn[n]),   32'h0);
         check($sformatf("ct_addr%0d", n), 32'(acc_addr[n]), 32'h2);
         check($sformatf("ct_done%0d", n), 32'(done_at[n]),  32'(2 + 3*n));
      end
      check("ct_wait_c2", 32'(wr_log[2]), 32'h6);

      // Fairness: master 0 requests continuously, master 2 once
      set_master(0, 1'b0, 3'd3, 16'h1111);
      set_master(2, 1'b0, 3'd4, 16'h2222);
      m_chipselect = 3'b001;
      run_cycles(9, 3'b001, 3'b100, 0);
      m_chipselect = '0;
      check("fr_count", 32'(acc_cnt), 32'd3);
      check("fr_data0", 32'(acc_data[0]), 32'h1111);
      check("fr_data1", 32'(acc_data[1]), 32'h2222);
      check("fr_data2", 32'(acc_data[2]), 32'h1111);
      check("fr_cyc1",  32'(acc_cyc[1]),  32'd4);
      check("fr_ignored_wait", 32'(wr_log[1][2]), 32'h1);
      check("fr_done2", 32'(done_at[2]), 32'd5);

      // Reset during ACCESS
      set_master(2, 1'b0, 3'd5, 16'h3333);
      set_master(0, 1'b0, 3'd3, 16'hBEEF);
      m_chipselect = 3'b100;
      @(negedge clk);
      check("mr_idle_cs", 32'(s_chipselect), 32'h0);
      @(negedge clk);
      check("mr_access_cs", 32'(s_chipselect), 32'h1);
      #2 reset_n = 1'b0;
      #1;
      check("mr_cs",    32'(s_chipselect),  32'h0);
      check("mr_wn",    32'(s_write_n),     32'h1);
      check("mr_wait",  32'(m_waitrequest), 32'h4);
      check("mr_rdata", 32'(m_readdata),    32'h0);
      @(posedge clk);
      #1 reset_n = 1'b1;
      m_chipselect = 3'b101;
      run_cycles(7, '0, '0, -1);
      check("mr_first",     32'(acc_data[0]), 32'hBEEF);
      check("mr_first_cyc", 32'(acc_cyc[0]),  32'd1);
      check("mr_second",    32'(acc_data[1]), 32'h3333);

`ifdef TIMER_IRQ_ROUTE_EN
      irq_pre_exp  = 3'b001;
      irq_post_exp = 3'b100;
`else
      irq_pre_exp  = 3'b111;
      irq_post_exp = 3'b111;
`endif
      // Interrupt routing
      irq_in = 1'b1;
      #1 check("irq_pre", 32'(irq_out), 32'(irq_pre_exp));
      irq_in = 1'b0;
      #1 check("irq_low", 32'(irq_out), 32'h0);
      set_master(2, 1'b0, 3'd1, 16'h0001);
      m_chipselect = 3'b100;
      run_cycles(4, '0, '0, -1);
      irq_in = 1'b1;
      #1 check("irq_m2", 32'(irq_out), 32'(irq_post_exp));
      // A write to address 1 with bit 0 clear must not move ownership
      set_master(0, 1'b0, 3'd1, 16'h0000);
      m_chipselect = 3'b001;
      run_cycles(4, '0, '0, -1);
      #1 check("irq_keep", 32'(irq_out), 32'(irq_post_exp));
      irq_in = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
